rp_trig_select: RTL
===================

RP_TRIG_SELECT -- requirements
Module: rp_trig_select

Interface
REQ-001 Parameter NCH, default 4, range 1..8: number of ADC channel trigger inputs.
REQ-002 Parameter HOLD_W, default 32: holdoff counter width.
REQ-003 adc_clk_i  in  1  ADC clock; the block's only clock.
REQ-004 adc_rstn_i  in  1  reset; asynchronous, active-low.
REQ-005 cfg_src_i  in  5  trigger source code, latched on arm.
REQ-006 cfg_mode_i  in  1  0 = single shot, 1 = auto re-arm.
REQ-007 cfg_holdoff_i  in  HOLD_W  auto-mode holdoff length.
REQ-008 arm_i  in  1  arm pulse.
REQ-009 disarm_i  in  1  disarm pulse (delay reached / acquisition reset).
REQ-010 cnt_clr_i  in  1  clears trig_cnt_o.
REQ-011 sw_trig_i  in  1  manual trigger request pulse.
REQ-012 dly_valp_i  in  1  valid-sample strobe qualifying manual trigger.
REQ-013 ch_trig_p_i / ch_trig_n_i  in  NCH  per-channel rising / falling edge pulses.
REQ-014 ext_trig_p_i, ext_trig_n_i, asg_trig_p_i, asg_trig_n_i  in  1 each  external and ASG edge pulses.
REQ-015 trig_o  out  1  registered trigger pulse, one cycle wide.
REQ-016 armed_o  out  1  high while state is ARMED.
REQ-017 trg_state_o  out  8  {state[1:0], sw_pending, src[4:0]}.
REQ-018 trig_cnt_o  out  32  trigger count.

Function
REQ-019 Source codes SHALL be: 0 none, 1 manual, 2/3 ext rise/fall, 4/5 ASG rise/fall, 6+2k / 7+2k channel k rise/fall for k < NCH; any other code is never satisfied.
REQ-020 The state machine SHALL have states IDLE=0, ARMED=1, HOLDOFF=2.
REQ-021 IDLE: arm_i with cfg_src_i != 0 latches src and goes to ARMED; arm_i with cfg_src_i = 0 is ignored.
REQ-022 ARMED or HOLDOFF: arm_i relatches src; state and holdoff count are unchanged.
REQ-023 ARMED: when the selected source is high in cycle t, trig_o SHALL be 1 in cycle t+1.
REQ-024 Single mode, on trigger: go to IDLE and clear src to 0.
REQ-025 Auto mode, on trigger: go to HOLDOFF and load the counter with cfg_holdoff_i.
REQ-026 HOLDOFF: counter = 0 goes to ARMED; otherwise the counter decrements; source events are ignored.
REQ-027 Minimum spacing between trig_o pulses in auto mode SHALL be cfg_holdoff_i + 2 cycles; cfg_holdoff_i = 0 gives a spacing of 2.
REQ-028 disarm_i SHALL force IDLE, src = 0, counter = 0 and sw_pending = 0, in any state.
REQ-029 disarm_i SHALL win over a simultaneous arm_i or source event; trig_o stays 0 in that case.
REQ-030 sw_pending SHALL set on sw_trig_i and clear on dly_valp_i or disarm_i; sw_trig_i wins over a simultaneous dly_valp_i.
REQ-031 Manual source SHALL be satisfied when sw_pending && dly_valp_i.
REQ-032 trig_cnt_o SHALL increment on each trig_o pulse and wrap modulo 2^32.
REQ-033 cnt_clr_i SHALL zero trig_cnt_o and win over a simultaneous increment.
REQ-034 cfg_mode_i and cfg_holdoff_i are sampled at the trigger cycle only.

Reset
REQ-035 Reset values SHALL be: state IDLE, src 0, sw_pending 0, holdoff counter 0, trig_o 0, armed_o 0, trg_state_o 0, trig_cnt_o 0.
REQ-036 Reset asserted mid-HOLDOFF or while ARMED SHALL abort with no trig_o pulse; after release the block stays IDLE until arm_i.

Structure
REQ-037 Package rp_trig_pkg SHALL hold the state encoding, the source-code constants (NONE, MAN, EXT_P/N, ASG_P/N, CH_BASE) and a channel-code helper function.
REQ-038 The holdoff down-counter (load, decrement, zero flag) SHALL be the sub-module rp_trig_holdoff.

Verification
REQ-039 Single mode, src=6, NCH=4: arm, then pulse ch_trig_p_i[0] at cycle 10 -> trig_o=1 at cycle 11, state IDLE, trg_state_o[4:0]=0, trig_cnt_o=1.
REQ-040 Auto mode, holdoff=10, src=2, ext_trig_p_i held high -> trig_o pulses every 12 cycles, trig_cnt_o counts each pulse.
REQ-041 Manual, src=1: sw_trig_i at cycle 5, dly_valp_i at cycle 9 -> trig_o at cycle 10 only, sw_pending cleared at cycle 10.
REQ-042 ARMED, src=4: disarm_i and asg_trig_p_i in the same cycle -> no trig_o, state IDLE, src=0.
REQ-043 src=21 with NCH=4 and all inputs toggling -> trig_o never asserts; NCH=8, src=21, ch_trig_n_i[7] pulse -> trig_o fires.
REQ-044 Auto HOLDOFF with counter=5: assert adc_rstn_i low -> all outputs 0 immediately, no trig_o after release until re-armed.

Source files
------------

// File: rtl/rp_trig_pkg.sv
// Shared state encoding and trigger-source codes for the trigger selector.
package rp_trig_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [4:0] SRC_NONE    = 5'd0;
  localparam logic [4:0] SRC_MAN     = 5'd1;
  localparam logic [4:0] SRC_EXT_P   = 5'd2;
  localparam logic [4:0] SRC_EXT_N   = 5'd3;
  localparam logic [4:0] SRC_ASG_P   = 5'd4;
  localparam logic [4:0] SRC_ASG_N   = 5'd5;
  localparam logic [4:0] SRC_CH_BASE = 5'd6;

  // Channel k uses the code pair CH_BASE+2k (rising) / CH_BASE+2k+1 (falling).
  function automatic logic [4:0] ch_code(input int unsigned k, input logic fall);
    ch_code = SRC_CH_BASE + 5'(k << 1) + {4'd0, fall};
  endfunction

endpackage

// File: rtl/rp_trig_holdoff.sv
// Holdoff down-counter: clear, load, decrement-to-zero with a zero flag.
module rp_trig_holdoff #(
  parameter int HOLD_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [HOLD_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [HOLD_W-1:0] cnt_d;
  logic [HOLD_W-1:0] cnt_q;

  assign zero_o = (cnt_q == {HOLD_W{1'b0}});

  // Next count: clear beats load beats decrement; never decrement below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {HOLD_W{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= {HOLD_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rp_trig_select.sv
// Trigger source selector: arm/disarm state machine, auto re-arm holdoff,
// manual trigger qualification and a free-running trigger counter.
module rp_trig_select
  import rp_trig_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int HOLD_W = 32
) (
  input  logic              adc_clk_i,
  input  logic              adc_rstn_i,
  input  logic [4:0]        cfg_src_i,
  input  logic              cfg_mode_i,
  input  logic [HOLD_W-1:0] cfg_holdoff_i,
  input  logic              arm_i,
  input  logic              disarm_i,
  input  logic              cnt_clr_i,
  input  logic              sw_trig_i,
  input  logic              dly_valp_i,
  input  logic [NCH-1:0]    ch_trig_p_i,
  input  logic [NCH-1:0]    ch_trig_n_i,
  input  logic              ext_trig_p_i,
  input  logic              ext_trig_n_i,
  input  logic              asg_trig_p_i,
  input  logic              asg_trig_n_i,
  output logic              trig_o,
  output logic              armed_o,
  output logic [7:0]        trg_state_o,
  output logic [31:0]       trig_cnt_o
);

  logic [1:0]  state_d, state_q;
  logic [4:0]  src_d, src_q;
  logic        sw_pend_d, sw_pend_q;
  logic        trig_d, trig_q;
  logic        armed_d, armed_q;
  logic [7:0]  trg_state_d, trg_state_q;
  logic [31:0] cnt_d, cnt_q;
  logic        src_hit_s;
  logic        hold_clr_s, hold_load_s, hold_dec_s, hold_zero_s;

  rp_trig_holdoff #(.HOLD_W(HOLD_W)) u_holdoff (
    .clk_i      (adc_clk_i),
    .rstn_i     (adc_rstn_i),
    .clr_i      (hold_clr_s),
    .load_i     (hold_load_s),
    .load_val_i (cfg_holdoff_i),
    .dec_i      (hold_dec_s),
    .zero_o     (hold_zero_s)
  );

  // Decode the latched source code; unmapped codes simply never hit.
  always_comb begin
    src_hit_s = 1'b0;
    case (src_q)
      SRC_MAN:   src_hit_s = sw_pend_q & dly_valp_i;
      SRC_EXT_P: src_hit_s = ext_trig_p_i;
      SRC_EXT_N: src_hit_s = ext_trig_n_i;
      SRC_ASG_P: src_hit_s = asg_trig_p_i;
      SRC_ASG_N: src_hit_s = asg_trig_n_i;
      default: begin
        for (int k = 0; k < NCH; k++) begin
          src_hit_s = src_hit_s
                    | ((src_q == ch_code(k, 1'b0)) & ch_trig_p_i[k])
                    | ((src_q == ch_code(k, 1'b1)) & ch_trig_n_i[k]);
        end
      end
    endcase
  end

  // State machine; disarm overrides everything, including a same-cycle hit.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    trig_d      = 1'b0;
    hold_clr_s  = 1'b0;
    hold_load_s = 1'b0;
    hold_dec_s  = 1'b0;
    if (disarm_i) begin
      state_d    = ST_IDLE;
      src_d      = SRC_NONE;
      hold_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i && (cfg_src_i != SRC_NONE)) begin
            src_d   = cfg_src_i;
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (src_hit_s) begin
            trig_d = 1'b1;
            if (cfg_mode_i) begin
              state_d     = ST_HOLDOFF;
              hold_load_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
              src_d   = SRC_NONE;
            end
          end else if (arm_i) begin
            src_d = cfg_src_i;
          end else begin
            src_d = src_q;
          end
        end
        ST_HOLDOFF: begin
          if (arm_i) begin
            src_d = cfg_src_i;
          end else begin
            src_d = src_q;
          end
          if (hold_zero_s) begin
            state_d = ST_ARMED;
          end else begin
            hold_dec_s = 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          src_d      = SRC_NONE;
          hold_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Manual request latch, trigger counter and registered status outputs.
  always_comb begin
    sw_pend_d = sw_pend_q;
    if (disarm_i) begin
      sw_pend_d = 1'b0;
    end else if (sw_trig_i) begin
      sw_pend_d = 1'b1;
    end else if (dly_valp_i) begin
      sw_pend_d = 1'b0;
    end else begin
      sw_pend_d = sw_pend_q;
    end
    if (cnt_clr_i) begin
      cnt_d = 32'd0;
    end else if (trig_d) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
    armed_d     = (state_d == ST_ARMED);
    trg_state_d = {state_d, sw_pend_d, src_d};
  end

  // All state and output registers.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_NONE;
      sw_pend_q   <= 1'b0;
      trig_q      <= 1'b0;
      armed_q     <= 1'b0;
      trg_state_q <= 8'd0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      sw_pend_q   <= sw_pend_d;
      trig_q      <= trig_d;
      armed_q     <= armed_d;
      trg_state_q <= trg_state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign trig_o      = trig_q;
  assign armed_o     = armed_q;
  assign trg_state_o = trg_state_q;
  assign trig_cnt_o  = cnt_q;

endmodule
